mult_accumulator: RTL
=====================

// Module: mult_accumulator
// PURPOSE
// Downstream stage of the pipelined 16x16 signed multiplier: consumes its 32-bit signed
// products and sums a frame of frame_len products into a wide signed accumulator.
// Saturating (or wrapping) add; the frame total is held behind a valid/ready output handshake.
// Input side is valid/ready so the multiplier pipeline can be stalled while a result is held.
// PARAMETERS
// PROD_W    32  product width (signed, two's complement)
// ACC_W     36  accumulator/result width (signed), ACC_W > PROD_W
// LEN_W     8   frame length counter width; frame_len==0 means 2**LEN_W products
// SATURATE  1   1: clamp on overflow; 0: wrap modulo 2**ACC_W
// PORTS
// clk         in   1       single clock, all state on rising edge
// rst         in   1       synchronous, active-high reset
// clear       in   1       synchronous abort of current frame/held result
// prod_valid  in   1       product valid
// prod_ready  out  1       stage can accept a product
// product     in   PROD_W  signed product from multiplier
// frame_len   in   LEN_W   products per frame, sampled on first product of frame
// acc_valid   out  1       frame result valid
// acc_ready   in   1       consumer accepts result
// acc_result  out  ACC_W   signed frame sum
// acc_sat     out  1       overflow occurred in this frame (sticky per frame)
// BEHAVIOUR
// - Reset (rst=1 at edge): state=IDLE, acc=0, cnt=0, acc_valid=0, acc_result=0, acc_sat=0.
//   prod_ready=0 while rst is high.
// - Priority: rst > clear > handshakes.
// - prod_ready = !rst && !clear && (state != HOLD), combinational. Accept = prod_valid & prod_ready.
// - FSM states: IDLE (no product of frame yet), ACCUM, HOLD (result presented).
//   IDLE, accept: acc <= sext(product); remaining <= len-1 (len = frame_len, 0 -> 2**LEN_W);
//     sat <= 0; next = HOLD if len==1, else ACCUM.
//   ACCUM, accept: acc <= addsat(acc, sext(product)); remaining--; next = HOLD when remaining was 1.
//   ACCUM, no accept: hold all state (bubbles allowed, any length).
//   HOLD: acc_valid=1; acc_result and acc_sat stable; on acc_ready -> IDLE, acc_valid=0 next cycle.
//     No same-cycle bypass: a product offered in HOLD is not accepted.
// - Latency: last product accepted at edge t -> acc_valid=1 after edge t (visible cycle t+1).
//   Back-to-back frames: one idle input cycle minimum (HOLD cycle) per frame.
// - Arithmetic: sum computed at ACC_W+1 bits; overflow = sum[ACC_W] != sum[ACC_W-1].
//   SATURATE=1: clamp to 2**(ACC_W-1)-1 / -2**(ACC_W-1), further adds continue from clamped value.
//   SATURATE=0: keep low ACC_W bits. Either way acc_sat sets on overflow, clears at frame start.
// - acc_result is registered and only updated on entry to HOLD; zeroed on rst/clear.
// - clear: state=IDLE, acc=0, acc_valid=0, acc_sat=0, acc_result=0; any held result is dropped;
//   frame_len re-sampled on next accepted product.
// - frame_len changes mid-frame are ignored.
// STRUCTURE
// - Package mult_pkg: PROD_W/ACC_W defaults, state enum typedef {IDLE, ACCUM, HOLD},
//   function sat_add(acc, addend, saturate) returning {sum, ovf}.
// - One sub-module natural: acc_sat_adder (combinational ACC_W add + overflow detect + clamp);
//   FSM, counter and output register stay in mult_accumulator.
// TESTING
// 1 frame_len=4, products 1,2,3,4 on consecutive cycles -> acc_valid one cycle after 4th accept,
//   acc_result=10, acc_sat=0.
// 2 frame_len=0 (256), product=0x4000_0000 every cycle -> after 32nd accept acc=0x7_FFFF_FFFF,
//   acc_sat=1, stays clamped; result 0x7_FFFF_FFFF after 256th. SATURATE=0: wrapped value, acc_sat=1.
// 3 Result held, acc_ready=0 for 5 cycles -> prod_ready=0, acc_result stable, no product consumed;
//   acc_ready=1 -> IDLE next cycle, next frame's first product accepted.
// 4 frame_len=3, products -5,7,-1 with prod_valid toggling 1,0,1,0,1 -> acc_result=1.
// 5 frame_len=4, clear after 2 accepted products -> IDLE, acc_valid=0; new frame_len=2 with 3,4 -> 7.
// 6 frame_len=1, product=0xFFFF_FFFF -> acc_result=0xF_FFFF_FFFF (-1); rst mid-HOLD -> all outputs 0.

Source files
------------

// File: rtl/mult_accumulator_pkg.sv
// Shared definitions for the product accumulator stage.
// Holds the default widths, the FSM state type and the saturating-add
// helper used by acc_sat_adder. The helper works on sign-extended 64-bit
// operands so a single function serves any accumulator width below 64.
package mult_accumulator_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 36;
  localparam int LEN_W_DEF  = 8;
  localparam int SAT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] sum;
    logic                 ovf;
  } sat_add_t;

  // acc/addend must be sign-extended acc_w-bit values. The sum is formed one
  // bit wider than acc_w, so bit acc_w is the true sign and a disagreement
  // with bit acc_w-1 flags overflow. On overflow without saturation only the
  // low acc_w bits of .sum are meaningful (modulo wrap).
  function automatic sat_add_t sat_add(input logic [SAT_MAX_W-1:0] acc,
                                       input logic [SAT_MAX_W-1:0] addend,
                                       input int unsigned          acc_w,
                                       input logic                 saturate);
    logic [SAT_MAX_W:0]   wide;
    logic [SAT_MAX_W-1:0] max_pos;
    sat_add_t             r;
    wide    = {acc[SAT_MAX_W-1], acc} + {addend[SAT_MAX_W-1], addend};
    max_pos = (SAT_MAX_W'(1) << (acc_w - 1)) - SAT_MAX_W'(1);
    r.ovf   = wide[acc_w] ^ wide[acc_w - 1];
    r.sum   = wide[SAT_MAX_W-1:0];
    if (r.ovf && saturate) begin
      r.sum = wide[acc_w] ? ~max_pos : max_pos;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_accumulator_if.sv
// Product-in / frame-sum-out bus of the accumulator stage.
//   prod_valid/prod_ready/product/frame_len : product stream from the multiplier
//   acc_valid/acc_ready/acc_result/acc_sat  : frame result toward the consumer
// master : the environment (multiplier side and result consumer)
// slave  : the accumulator stage
interface mult_accumulator_if
  import mult_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [PROD_W-1:0] product;
  logic        [LEN_W-1:0]  frame_len;
  logic                     acc_valid;
  logic                     acc_ready;
  logic signed [ACC_W-1:0]  acc_result;
  logic                     acc_sat;

  modport master (
    output prod_valid, product, frame_len, acc_ready,
    input  prod_ready, acc_valid, acc_result, acc_sat
  );

  modport slave (
    input  prod_valid, product, frame_len, acc_ready,
    output prod_ready, acc_valid, acc_result, acc_sat
  );
endinterface

// File: rtl/mult_accumulator_acc_sat_adder.sv
// acc_sat_adder: combinational ACC_W-bit signed add with overflow detect.
// Ports:
//   acc     in  ACC_W  running accumulator value
//   addend  in  ACC_W  sign-extended product
//   sum     out ACC_W  clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//   ovf     out 1      the true sum did not fit in ACC_W bits
module acc_sat_adder
  import mult_accumulator_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] addend,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  sat_add_t res;
  logic     unused_hi;

  always_comb begin
    res = sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(addend), ACC_W, SATURATE);
  end

  assign sum       = res.sum[ACC_W-1:0];
  assign ovf       = res.ovf;
  assign unused_hi = ^res.sum[SAT_MAX_W-1:ACC_W];

endmodule

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums frames of signed products into a wide accumulator.
// A frame of frame_len products (0 meaning 2**LEN_W) is summed with a
// saturating or wrapping add; the total is then held behind acc_valid/
// acc_ready while the product input is stalled.
// Ports:
//   clk    in  1  clock, all state on the rising edge
//   rst    in  1  synchronous active-high reset
//   clear  in  1  synchronous abort of the current frame / held result
//   bus    slave modport of mult_accumulator_if (product in, result out)
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter int PROD_W   = PROD_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  mult_accumulator_if.slave bus
);

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [LEN_W-1:0]   rem_q, rem_d;
  logic                      sat_q, sat_d;
  logic signed [ACC_W-1:0]   result_q, result_d;

  logic signed [PROD_W-1:0]  prod_in;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   add_sum;
  logic                      add_ovf;
  logic                      accept;

  assign prod_in  = bus.product;
  assign prod_ext = ACC_W'(prod_in);

  // Ready is withheld combinationally during rst/clear so no product is
  // consumed on a cycle whose state update is discarded.
  assign bus.prod_ready = !rst && !clear && (state_q != HOLD);
  assign accept         = bus.prod_valid && bus.prod_ready;

  assign bus.acc_valid  = (state_q == HOLD);
  assign bus.acc_result = result_q;
  assign bus.acc_sat    = sat_q;

  acc_sat_adder #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_adder (
    .acc    (acc_q),
    .addend (prod_ext),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    sat_d    = sat_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // frame_len - 1 wraps to all ones for frame_len == 0, which is
          // exactly the remaining count of a 2**LEN_W frame.
          acc_d = prod_ext;
          rem_d = bus.frame_len - LEN_W'(1);
          sat_d = 1'b0;
          if (bus.frame_len == LEN_W'(1)) begin
            state_d  = HOLD;
            result_d = prod_ext;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          sat_d = sat_q | add_ovf;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d  = HOLD;
            result_d = add_sum;
          end
        end
      end
      HOLD: begin
        if (bus.acc_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      sat_q    <= sat_d;
      result_q <= result_d;
    end
  end

endmodule
